// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the cpu_ctrl sequencer: opcodes, FSM states,
// instruction field positions and the branch target table.
package definitions;

    typedef enum logic [2:0] {
        kAND = 3'd0,
        kADD = 3'd1,
        kXOR = 3'd2,
        kLSH = 3'd3,
        kSTR = 3'd4,
        kLDM = 3'd5,
        kLDI = 3'd6,
        kBNE = 3'd7
    } op_mne;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5
    } ctrl_state_t;

    localparam logic [8:0] HALT_INSTR_DEFAULT = 9'h1FF;

    localparam int unsigned OP_MSB      = 8;
    localparam int unsigned OP_LSB      = 6;
    localparam int unsigned RA_MSB      = 5;
    localparam int unsigned RA_LSB      = 3;
    localparam int unsigned RB_MSB      = 2;
    localparam int unsigned RB_LSB      = 0;
    localparam int unsigned LSH_DIR_BIT = 5;
    localparam int unsigned LSH_RA_MSB  = 4;

    // BNE targets, indexed by the rb field of the instruction
    localparam int unsigned BRANCH_TARGETS [8] = '{
        32'h00, 32'h08, 32'h0C, 32'h10, 32'h20, 32'h30, 32'h40, 32'h80
    };

endpackage

// File: rtl/cpu_ctrl_branch_lut.sv
// Combinational 8-entry branch target table: rb index to PC target.
module branch_lut
    import definitions::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic [2:0]      idx_i,
    output logic [PC_W-1:0] target_o
);

    always_comb begin
        target_o = PC_W'(BRANCH_TARGETS[idx_i]);
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control sequencer for the 9-bit RISC core.
// Optional carry chain enabled by defining CPU_CTRL_CARRY_CHAIN_EN.
module cpu_ctrl
    import definitions::*;
#(
    parameter int unsigned PC_W       = 8,
    parameter logic [8:0]  HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] pc,
    input  logic [8:0]      instr,
    output logic [2:0]      alu_op,
    output logic            alu_rsh,
    output logic            alu_ci,
    input  logic [7:0]      alu_rslt,
    input  logic            alu_co,
    output logic [2:0]      rf_ra,
    output logic [2:0]      rf_rb,
    output logic [2:0]      rf_wa,
    output logic            rf_we,
    output logic            wd_sel,
    output logic            imm_sel,
    output logic [2:0]      imm,
    output logic            dm_we,
    output logic            done
);

    ctrl_state_t     state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [8:0]      ir_q, ir_d;
    logic [7:0]      rslt_q, rslt_d;
    logic [PC_W-1:0] branch_target;
    op_mne           op;
    logic            is_lsh;
    logic [2:0]      ra;
    logic            writes_rf;
    logic            wb_active;

    branch_lut #(.PC_W(PC_W)) u_branch_lut (
        .idx_i    (ir_q[RB_MSB:RB_LSB]),
        .target_o (branch_target)
    );

    // Datapath controls decode straight from the IR, so they stay put from EXEC through WB
    assign op        = op_mne'(ir_q[OP_MSB:OP_LSB]);
    assign is_lsh    = (op == kLSH);
    assign ra        = is_lsh ? {1'b0, ir_q[LSH_RA_MSB:RA_LSB]} : ir_q[RA_MSB:RA_LSB];
    assign writes_rf = (op inside {kAND, kADD, kXOR, kLSH, kLDI, kLDM});

    // Gating with reset keeps an aborted WB from committing anything
    assign wb_active = (state_q == WB) && !reset;

    assign pc      = pc_q;
    assign alu_op  = ir_q[OP_MSB:OP_LSB];
    assign alu_rsh = is_lsh & ir_q[LSH_DIR_BIT];
    assign rf_ra   = ra;
    assign rf_rb   = ir_q[RB_MSB:RB_LSB];
    assign rf_wa   = ra;
    assign imm_sel = (op == kLDI);
    assign imm     = ir_q[RB_MSB:RB_LSB];
    assign wd_sel  = (op == kLDM);
    assign rf_we   = wb_active & writes_rf;
    assign dm_we   = wb_active & (op == kSTR);
    assign done    = (state_q == HALT);

`ifdef CPU_CTRL_CARRY_CHAIN_EN
    logic cf_q, cf_d;
    logic co_q, co_d;

    assign alu_ci = cf_q;

    always_comb begin
        cf_d = cf_q;
        co_d = co_q;
        case (state_q)
            IDLE, HALT: if (start) cf_d = 1'b0;
            EXEC:       co_d = alu_co;
            WB:         if (op == kADD) cf_d = co_q;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cf_q <= 1'b0;
            co_q <= 1'b0;
        end else begin
            cf_q <= cf_d;
            co_q <= co_d;
        end
    end
`else
    logic unused_alu_co;

    assign alu_ci        = 1'b0;
    assign unused_alu_co = alu_co;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        rslt_d  = rslt_q;
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            FETCH: begin
                ir_d    = instr;
                state_d = (instr == HALT_INSTR) ? HALT : EXEC;
            end
            EXEC: begin
                rslt_d  = alu_rslt;
                state_d = (op == kLDM) ? MEM : WB;
            end
            MEM: begin
                state_d = WB;
            end
            WB: begin
                if ((op == kBNE) && (rslt_q != '0)) begin
                    pc_d = branch_target;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
                state_d = FETCH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            rslt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            rslt_q  <= rslt_d;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed, table-driven bench for cpu_ctrl with hand-written halt/reset sequences.
module tb_cpu_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pc;
    logic [8:0] instr;
    logic [2:0] alu_op;
    logic       alu_rsh;
    logic       alu_ci;
    logic [7:0] alu_rslt;
    logic       alu_co;
    logic [2:0] rf_ra;
    logic [2:0] rf_rb;
    logic [2:0] rf_wa;
    logic       rf_we;
    logic       wd_sel;
    logic       imm_sel;
    logic [2:0] imm;
    logic       dm_we;
    logic       done;

    logic [8:0] rom [256];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

`ifdef CPU_CTRL_CARRY_CHAIN_EN
    localparam logic CI_AFTER_CARRY = 1'b1;
`else
    localparam logic CI_AFTER_CARRY = 1'b0;
`endif

    typedef struct {
        logic [8:0] ins;
        logic [7:0] addr;
        logic [7:0] rslt;
        logic       co;
        logic [2:0] op;
        logic       rsh;
        logic       ci;
        logic [2:0] ra;
        logic [2:0] rb;
        logic       isel;
        logic [2:0] imm;
        logic       mem;
        logic       we;
        logic [2:0] wa;
        logic       wd;
        logic       dmwe;
        logic [7:0] npc;
    } vec_t;

    localparam int NV = 10;
    vec_t vt [NV];

    assign instr = rom[pc];

    always #5 clk = ~clk;

    cpu_ctrl #(.PC_W(8), .HALT_INSTR(9'h1FF)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pc       (pc),
        .instr    (instr),
        .alu_op   (alu_op),
        .alu_rsh  (alu_rsh),
        .alu_ci   (alu_ci),
        .alu_rslt (alu_rslt),
        .alu_co   (alu_co),
        .rf_ra    (rf_ra),
        .rf_rb    (rf_rb),
        .rf_wa    (rf_wa),
        .rf_we    (rf_we),
        .wd_sel   (wd_sel),
        .imm_sel  (imm_sel),
        .imm      (imm),
        .dm_we    (dm_we),
        .done     (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        alu_rslt = '0;
        alu_co   = 1'b0;
        reset    = 1'b1;
        start    = 1'b0;
        for (int a = 0; a < 256; a++) rom[a] = '0;

        //        ins           addr   rslt   co    op    rsh   ci              ra    rb    isel  imm   mem   we    wa    wd    dmwe  npc
        vt[0] = '{9'b110_001_101, 8'h00, 8'h05, 1'b0, 3'd6, 1'b0, 1'b0,           3'd1, 3'd5, 1'b1, 3'd5, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 8'h01};
        vt[1] = '{9'b001_001_010, 8'h01, 8'h0A, 1'b1, 3'd1, 1'b0, 1'b0,           3'd1, 3'd2, 1'b0, 3'd2, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 8'h02};
        vt[2] = '{9'b001_011_100, 8'h02, 8'h33, 1'b0, 3'd1, 1'b0, CI_AFTER_CARRY, 3'd3, 3'd4, 1'b0, 3'd4, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 8'h03};
        vt[3] = '{9'b011_110_011, 8'h03, 8'h80, 1'b1, 3'd3, 1'b1, 1'b0,           3'd2, 3'd3, 1'b0, 3'd3, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h04};
        vt[4] = '{9'b111_001_011, 8'h04, 8'h01, 1'b0, 3'd7, 1'b0, 1'b0,           3'd1, 3'd3, 1'b0, 3'd3, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'h10};
        vt[5] = '{9'b101_101_110, 8'h10, 8'h22, 1'b0, 3'd5, 1'b0, 1'b0,           3'd5, 3'd6, 1'b0, 3'd6, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 8'h11};
        vt[6] = '{9'b100_111_000, 8'h11, 8'h44, 1'b0, 3'd4, 1'b0, 1'b0,           3'd7, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 8'h12};
        vt[7] = '{9'b111_010_101, 8'h12, 8'h00, 1'b0, 3'd7, 1'b0, 1'b0,           3'd2, 3'd5, 1'b0, 3'd5, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 8'h13};
        vt[8] = '{9'b010_000_001, 8'h13, 8'h5A, 1'b0, 3'd2, 1'b0, 1'b0,           3'd0, 3'd1, 1'b0, 3'd1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h14};
        vt[9] = '{9'b000_110_111, 8'h14, 8'h06, 1'b0, 3'd0, 1'b0, 1'b0,           3'd6, 3'd7, 1'b0, 3'd7, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 8'h15};
        for (int i = 0; i < NV; i++) rom[vt[i].addr] = vt[i].ins;
        rom[8'h15] = 9'h1FF;

        // Reset values
        do_reset();
        chk("rst_pc", pc, 0);
        chk("rst_done", done, 0);
        chk("rst_we", {rf_we, dm_we}, 0);
        chk("rst_alu", {alu_op, alu_rsh, alu_ci}, 0);
        chk("rst_sel", {imm_sel, wd_sel, imm}, 0);
        chk("rst_addr", {rf_ra, rf_rb, rf_wa}, 0);

        // Program walk: now in FETCH of pc 0 after the start pulse
        pulse_start();
        for (int i = 0; i < NV; i++) begin
            alu_rslt = vt[i].rslt;
            alu_co   = vt[i].co;
            chk($sformatf("v%0d_fetch_pc", i), pc, vt[i].addr);
            chk($sformatf("v%0d_fetch_we", i), {rf_we, dm_we}, 0);
            @(negedge clk);
            chk($sformatf("v%0d_exec_op", i), alu_op, vt[i].op);
            chk($sformatf("v%0d_exec_rsh", i), alu_rsh, vt[i].rsh);
            chk($sformatf("v%0d_exec_ci", i), alu_ci, vt[i].ci);
            chk($sformatf("v%0d_exec_ra", i), rf_ra, vt[i].ra);
            chk($sformatf("v%0d_exec_rb", i), rf_rb, vt[i].rb);
            chk($sformatf("v%0d_exec_imm", i), {imm_sel, imm}, {vt[i].isel, vt[i].imm});
            chk($sformatf("v%0d_exec_we", i), {rf_we, dm_we}, 0);
            if (vt[i].mem) begin
                @(negedge clk);
                chk($sformatf("v%0d_mem_we", i), {rf_we, dm_we}, 0);
                chk($sformatf("v%0d_mem_pc", i), pc, vt[i].addr);
            end
            @(negedge clk);
            chk($sformatf("v%0d_wb_rfwe", i), rf_we, vt[i].we);
            chk($sformatf("v%0d_wb_dmwe", i), dm_we, vt[i].dmwe);
            chk($sformatf("v%0d_wb_wa", i), rf_wa, vt[i].wa);
            chk($sformatf("v%0d_wb_wdsel", i), wd_sel, vt[i].wd);
            chk($sformatf("v%0d_wb_pc", i), pc, vt[i].addr);
            chk($sformatf("v%0d_wb_op_held", i), alu_op, vt[i].op);
            @(negedge clk);
            chk($sformatf("v%0d_next_pc", i), pc, vt[i].npc);
            chk($sformatf("v%0d_next_we", i), {rf_we, dm_we}, 0);
        end
        @(negedge clk);
        chk("halt_end_done", done, 1);
        chk("halt_end_pc", pc, 8'h15);

        // Halt at pc 2, then restart
        do_reset();
        for (int a = 0; a < 256; a++) rom[a] = '0;
        rom[0] = 9'b110_001_101;
        rom[1] = 9'b010_000_001;
        rom[2] = 9'h1FF;
        pulse_start();
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("halt2_reached", done, 1);
        chk("halt2_cycles", cyc, 7);
        repeat (3) @(negedge clk);
        chk("halt2_done_hold", done, 1);
        chk("halt2_pc_hold", pc, 2);
        chk("halt2_we", {rf_we, dm_we}, 0);
        pulse_start();
        chk("restart_pc", pc, 0);
        chk("restart_done", done, 0);
        @(negedge clk);
        pulse_start();
        chk("ignored_start_we", rf_we, 1);
        chk("ignored_start_pc", pc, 0);
        @(negedge clk);
        chk("ignored_start_next_pc", pc, 1);

        // Reset during WB of the XOR at pc 1
        @(negedge clk);
        @(negedge clk);
        chk("pre_abort_we", rf_we, 1);
        reset = 1'b1;
        #1;
        chk("abort_we", {rf_we, dm_we}, 0);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_next_we", {rf_we, dm_we}, 0);
        chk("abort_pc", pc, 0);
        chk("abort_done", done, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("idle_hold_%0d", k), {pc, rf_we, dm_we, done}, 0);
        end

        // Simultaneous reset and start: reset wins, machine stays idle
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst_start_idle_%0d", k), {pc, rf_we, dm_we, done}, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
